// File: rtl/sign_feeder_if.sv
// Handshake and core-bus bundle between a host, the sign_feeder and the signP core.
// Latency: none, wires only.
// Backpressure: tri/pt use valid-ready; res is a one-cycle strobe; the core bus is cadence-driven.
//
// Ports: tri_* triangle offer, pt_* test-point offer, res_* result strobe,
//        sp_* serial point bus to/from the edge-sign core.
// Modports: master = host/core side, slave = sign_feeder side.
interface sign_feeder_if #(parameter int W = 11);
   logic           tri_valid;
   logic           tri_ready;
   logic [3*W-1:0] tri_x;
   logic [3*W-1:0] tri_y;
   logic           pt_valid;
   logic           pt_ready;
   logic [W-1:0]   pt_x;
   logic [W-1:0]   pt_y;
   logic           res_valid;
   logic           res_s;
   logic [1:0]     res_edge;
   logic           sp_r;
   logic [W-1:0]   sp_i1;
   logic [W-1:0]   sp_i2;
   logic           sp_s;

   modport slave (
      input  tri_valid, tri_x, tri_y, pt_valid, pt_x, pt_y, sp_s,
      output tri_ready, pt_ready, res_valid, res_s, res_edge, sp_r, sp_i1, sp_i2
   );

   modport master (
      output tri_valid, tri_x, tri_y, pt_valid, pt_x, pt_y, sp_s,
      input  tri_ready, pt_ready, res_valid, res_s, res_edge, sp_r, sp_i1, sp_i2
   );
endinterface

// File: rtl/sign_feeder.sv
// Feeds a triangle and test points to the signP edge-sign core and returns its sign results.
// Latency: point accept -> res_valid 5 cycles (15 with INSIDE_TEST_EN); one point per 5-cycle slot.
// Backpressure: pt_ready only in the PT slot; tri_ready in IDLE or in a PT slot with no point offered.
//
// Ports: clk, r_n (async active-low); bus (sign_feeder_if.slave) carries the triangle
//        and point handshakes, the result strobe and the core's sp_r/sp_i1/sp_i2/sp_s bus.
// Optional: `define INSIDE_TEST_EN issues each point against all three edges and
//           returns a single inside/outside verdict per point.
module sign_feeder #(
   parameter int W = 11
) (
   input  logic           clk,
   input  logic           r_n,
   sign_feeder_if.slave   bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_RST, S_V0, S_V1, S_V2, S_PT, S_A, S_B, S_C, S_D
   } state_t;

   state_t         state_q;
   logic [3*W-1:0] tx_q;
   logic [3*W-1:0] ty_q;
   logic           sp_r_q;
   logic [W-1:0]   sp_i1_q;
   logic [W-1:0]   sp_i2_q;
   logic           live_q;
   logic           res_valid_q;
   logic           res_s_q;
   logic [1:0]     res_edge_q;
   logic [1:0]     edge_q;

   logic           grp_start_d;
   logic           pt_ready_d;
   logic           tri_ready_d;
   logic           pt_acc_d;
   logic           tri_acc_d;
   logic [1:0]     edge_inc_d;

`ifdef INSIDE_TEST_EN
   // grp_q counts the iteration within a point's three-edge group.
   logic [1:0]     grp_q;
   logic [1:0]     grp_edge_q;
   logic           s0_q;
   logic           s1_q;
   assign grp_start_d = (grp_q == 2'd0);
`else
   assign grp_start_d = 1'b1;
`endif

   assign pt_ready_d  = (state_q == S_PT) && grp_start_d;
   // A new triangle may only displace an empty slot; an offered point wins.
   assign tri_ready_d = r_n && ((state_q == S_IDLE) || (pt_ready_d && !bus.pt_valid));
   assign pt_acc_d    = pt_ready_d && bus.pt_valid;
   assign tri_acc_d   = tri_ready_d && bus.tri_valid;
   assign edge_inc_d  = (edge_q == 2'd2) ? 2'd0 : edge_q + 2'd1;

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state_q     <= S_IDLE;
         tx_q        <= '0;
         ty_q        <= '0;
         sp_r_q      <= 1'b1;
         sp_i1_q     <= '0;
         sp_i2_q     <= '0;
         live_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_s_q     <= 1'b0;
         res_edge_q  <= 2'd0;
         edge_q      <= 2'd0;
`ifdef INSIDE_TEST_EN
         grp_q       <= 2'd0;
         grp_edge_q  <= 2'd0;
         s0_q        <= 1'b0;
         s1_q        <= 1'b0;
`endif
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               sp_r_q <= 1'b1;
               if (tri_acc_d) begin
                  tx_q    <= bus.tri_x;
                  ty_q    <= bus.tri_y;
                  edge_q  <= 2'd0;
                  state_q <= S_RST;
               end
            end
            S_RST: begin
               sp_r_q  <= 1'b0;
               sp_i1_q <= tx_q[W-1:0];
               sp_i2_q <= ty_q[W-1:0];
               state_q <= S_V0;
            end
            S_V0: begin
               sp_i1_q <= tx_q[2*W-1:W];
               sp_i2_q <= ty_q[2*W-1:W];
               state_q <= S_V1;
            end
            S_V1: begin
               sp_i1_q <= tx_q[3*W-1:2*W];
               sp_i2_q <= ty_q[3*W-1:2*W];
               state_q <= S_V2;
            end
            S_V2: state_q <= S_PT;
            S_PT: begin
               if (tri_acc_d) begin
                  // Reload: drop this slot and restart the core with the new triangle.
                  tx_q    <= bus.tri_x;
                  ty_q    <= bus.tri_y;
                  sp_r_q  <= 1'b1;
                  edge_q  <= 2'd0;
                  live_q  <= 1'b0;
`ifdef INSIDE_TEST_EN
                  grp_q   <= 2'd0;
`endif
                  state_q <= S_RST;
               end else begin
                  if (pt_acc_d) begin
                     sp_i1_q <= bus.pt_x;
                     sp_i2_q <= bus.pt_y;
                     live_q  <= 1'b1;
                  end else if (grp_start_d) begin
                     // Bubble: bus keeps the last point so the core sees a stable value.
                     live_q  <= 1'b0;
                  end
                  state_q <= S_A;
               end
            end
            S_A: state_q <= S_B;
            S_B: state_q <= S_C;
            S_C: state_q <= S_D;
            S_D: begin
               edge_q  <= edge_inc_d;
               state_q <= S_PT;
`ifdef INSIDE_TEST_EN
               case (grp_q)
                  2'd0: begin
                     s0_q       <= bus.sp_s;
                     grp_edge_q <= edge_q;
                     // A bubble uses up one iteration without opening a group.
                     grp_q      <= live_q ? 2'd1 : 2'd0;
                  end
                  2'd1: begin
                     s1_q  <= bus.sp_s;
                     grp_q <= 2'd2;
                  end
                  default: begin
                     res_s_q     <= (s0_q == s1_q) && (s1_q == bus.sp_s);
                     res_valid_q <= live_q;
                     res_edge_q  <= grp_edge_q;
                     grp_q       <= 2'd0;
                  end
               endcase
`else
               res_s_q     <= bus.sp_s;
               res_valid_q <= live_q;
               res_edge_q  <= edge_q;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.tri_ready = tri_ready_d;
   assign bus.pt_ready  = pt_ready_d;
   assign bus.res_valid = res_valid_q;
   assign bus.res_s     = res_s_q;
   assign bus.res_edge  = res_edge_q;
   assign bus.sp_r      = sp_r_q;
   assign bus.sp_i1     = sp_i1_q;
   assign bus.sp_i2     = sp_i2_q;

endmodule

// File: tb/tb_sign_feeder.sv
// Bench for sign_feeder: a cycle-level signP core model answers on the sp_* bus, a driver
// offers triangles and points (directed then random), and a monitor scores every result
// strobe against an expected queue filled from edge-sign arithmetic on the offered data.
module tb_sign_feeder;
   localparam int W = 11;
`ifdef INSIDE_TEST_EN
   localparam int LAT = 15;
`else
   localparam int LAT = 5;
`endif

   typedef struct {
      bit       s;
      bit [1:0] e;
      int       t;
   } exp_t;

   logic clk = 1'b0;
   logic r_n = 1'b0;
   sign_feeder_if #(.W(W)) bus ();

   sign_feeder #(.W(W)) dut (.clk(clk), .r_n(r_n), .bus(bus.slave));

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q[$];
   int   mvx[3], mvy[3];   // triangle as loaded by the bench
   int   edge_m = 0;       // edge the next PT slot will be computed against

   always @(posedge clk) cyc++;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   // Edge e pivots v[e] with direction v[(e+2)%3]-v[e]; sign is m1 < m2.
   function automatic bit edge_sign(input int vx[3], input int vy[3], input int e,
                                    input int px, input int py);
      int o, m1, m2;
      o  = (e + 2) % 3;
      m1 = (px - vx[e]) * (vy[o] - vy[e]);
      m2 = (py - vy[e]) * (vx[o] - vx[e]);
      return m1 < m2;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // signP core model: three vertex cycles after reset, then a 5-cycle slot per point
   // whose last cycle presents the sign for the rotating edge.
   int ck = -1;
   int cvx[3], cvy[3];
   always @(posedge clk) begin
      #1;
      if (!r_n || bus.sp_r) begin
         ck = -1;
         bus.sp_s = 1'b0;
      end else begin
         ck++;
         bus.sp_s = 1'b0;
         if (ck < 3) begin
            cvx[ck] = sx(bus.sp_i1);
            cvy[ck] = sx(bus.sp_i2);
         end else if ((ck - 3) % 5 == 4) begin
            bus.sp_s = edge_sign(cvx, cvy, ((ck - 3) / 5) % 3, sx(bus.sp_i1), sx(bus.sp_i2));
         end
      end
   end

   // Monitor: every result strobe must match the oldest outstanding expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (r_n && bus.res_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: res_valid with nothing pending (s=%0d edge=%0d)",
                     bus.res_s, bus.res_edge);
         end else begin
            e = q.pop_front();
            if (bus.res_s !== e.s || bus.res_edge !== e.e || cyc - e.t != LAT) begin
               errors++;
               $display("FAIL result: got s=%0d edge=%0d lat=%0d, expected s=%0d edge=%0d lat=%0d",
                        bus.res_s, bus.res_edge, cyc - e.t, e.s, e.e, LAT);
            end
         end
      end
   end

   task automatic load(input int vx[3], input int vy[3]);
      int n;
      logic [W-1:0] bx[3], by[3];
      for (int i = 0; i < 3; i++) begin
         bx[i] = W'(vx[i]);
         by[i] = W'(vy[i]);
      end
      bus.tri_x     = {bx[2], bx[1], bx[0]};
      bus.tri_y     = {by[2], by[1], by[0]};
      bus.pt_valid  = 1'b0;
      bus.tri_valid = 1'b1;
      n = 0;
      while (!bus.tri_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.tri_ready) begin
         chk("tri_accept_timeout", 0, 1);
         bus.tri_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.tri_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mvx[i] = sx(bx[i]);
         mvy[i] = sx(by[i]);
      end
      edge_m = 0;
      chk("rst_slot_sp_r", bus.sp_r, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("vtx_sp_r", bus.sp_r, 0);
         chk("vtx_x", int'(bus.sp_i1), int'(bx[i]));
         chk("vtx_y", int'(bus.sp_i2), int'(by[i]));
      end
      @(posedge clk); #1;
      chk("first_pt_ready", bus.pt_ready, 1);
   endtask

   // One PT slot: live point or bubble. Expectation is pushed at the accepting cycle.
   task automatic slot(input bit live, input int x, input int y);
      int n;
      exp_t e;
      bus.pt_x     = W'(x);
      bus.pt_y     = W'(y);
      bus.pt_valid = live;
      n = 0;
      while (!bus.pt_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.pt_ready) begin
         chk("pt_slot_timeout", 0, 1);
         bus.pt_valid = 1'b0;
         return;
      end
      if (live && bus.tri_valid) chk("point_wins_tri_ready", bus.tri_ready, 0);
      if (live) begin
         e.t = cyc;
         e.e = 2'(edge_m);
`ifdef INSIDE_TEST_EN
         e.s = (edge_sign(mvx, mvy, edge_m, sx(W'(x)), sx(W'(y))) ==
                edge_sign(mvx, mvy, (edge_m + 1) % 3, sx(W'(x)), sx(W'(y)))) &&
               (edge_sign(mvx, mvy, (edge_m + 1) % 3, sx(W'(x)), sx(W'(y))) ==
                edge_sign(mvx, mvy, (edge_m + 2) % 3, sx(W'(x)), sx(W'(y))));
`else
         e.s = edge_sign(mvx, mvy, edge_m, sx(W'(x)), sx(W'(y)));
         edge_m = (edge_m + 1) % 3;
`endif
         q.push_back(e);
      end else begin
         edge_m = (edge_m + 1) % 3;
      end
      @(posedge clk); #1;
      bus.pt_valid = 1'b0;
   endtask

   initial begin
      int tvx[3], tvy[3];
      int r, n;
      bus.tri_valid = 1'b0;
      bus.tri_x     = '0;
      bus.tri_y     = '0;
      bus.pt_valid  = 1'b0;
      bus.pt_x      = '0;
      bus.pt_y      = '0;
      bus.sp_s      = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tri_ready", bus.tri_ready, 0);
      chk("rst_sp_r", bus.sp_r, 1);
      chk("rst_res_valid", bus.res_valid, 0);
      r_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_tri_ready", bus.tri_ready, 1);
      chk("idle_pt_ready", bus.pt_ready, 0);
      chk("idle_sp_r", bus.sp_r, 1);
      chk("idle_res_edge", bus.res_edge, 0);
      chk("idle_sp_i1", int'(bus.sp_i1), 0);

      // Directed triangle and points
      tvx = '{0, 10, 0};
      tvy = '{0, 0, 10};
      load(tvx, tvy);
      slot(1, 2, 2);
      slot(1, 1, -4);
      slot(0, 0, 0);
      slot(1, 20, 0);

      // Point and triangle offered together: the point is taken.
      bus.tri_x = '1;
      bus.tri_y = '1;
      bus.tri_valid = 1'b1;
      slot(1, 3, 3);
      bus.tri_valid = 1'b0;

      // Reload from a PT slot with no point offered.
      tvx = '{5, 100, 5};
      tvy = '{5, 5, 100};
      load(tvx, tvy);
      slot(1, 20, 20);
      slot(1, -30, 40);

      // Async reset in state C of a live iteration.
      slot(1, 2, 2);
      repeat (2) @(posedge clk);
      #1;
      r_n = 1'b0;
      q.delete();
      #1;
      chk("abort_sp_r", bus.sp_r, 1);
      chk("abort_res_valid", bus.res_valid, 0);
      chk("abort_sp_i1", int'(bus.sp_i1), 0);
      chk("abort_pt_ready", bus.pt_ready, 0);
      chk("abort_tri_ready", bus.tri_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      r_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_idle_tri_ready", bus.tri_ready, 1);
      chk("abort_idle_pt_ready", bus.pt_ready, 0);

      // Randomized triangles, points, bubbles and reloads.
      tvx = '{0, 10, 0};
      tvy = '{0, 0, 10};
      load(tvx, tvy);
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0) begin
            for (int k = 0; k < 3; k++) begin
               tvx[k] = int'($urandom_range(0, 1000)) - 500;
               tvy[k] = int'($urandom_range(0, 1000)) - 500;
            end
            load(tvx, tvy);
         end else if (r < 5) begin
            slot(0, 0, 0);
         end else begin
            slot(1, int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500);
         end
      end

      // Drain outstanding results.
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); n++;
      end
      chk("drain_pending", q.size(), 0);
      repeat (20) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
